// File: rtl/sr_cmd_debouncer.sv
// -----------------------------------------------------------------------------
// sr_cmd_debouncer
//   Command front end for an enabled SR flip-flop. It turns two raw request
//   levels into clean one-cycle command pulses. Each channel is sampled,
//   debounced and rising-edge detected. The result is registered as S/R/enable.
//   If both channels rise in the same cycle, no command is issued and only
//   collision is pulsed. Because of this, S=R=1 can never leave the block.
//
// Configuration macro:
//   SR_CMD_SYNC_EN  defined   : a 2-flop synchronizer replaces the single
//                               sampling flop (for asynchronous/button inputs).
//                               This adds one cycle of latency.
//                   undefined : a single sampling flop. The inputs must already
//                               be synchronous to clk.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive differing samples needed to flip a level (>=1)
//
// Ports:
//   clk        in   single clock, all logic on posedge
//   rst        in   synchronous, active-high reset
//   set_in     in   raw set request level
//   reset_in   in   raw reset request level
//   S          out  set command pulse (registered)
//   R          out  reset command pulse (registered)
//   enable     out  command-valid pulse (registered)
//   collision  out  both requests rose in the same cycle (registered)
// -----------------------------------------------------------------------------
module sr_cmd_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic set_in,
  input  logic reset_in,
  output logic S,
  output logic R,
  output logic enable,
  output logic collision
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Channel 0 carries the set request and channel 1 carries the reset request.
  logic [1:0] raw;
  assign raw = {reset_in, set_in};

  logic [1:0] samp_q;            // sampled (or synchronized) input, x_s
  logic [1:0] deb_q, deb_d;      // debounced levels
  logic [1:0] deb_dly_q;         // debounced levels delayed one cycle
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  logic s_q, r_q, en_q, coll_q;
  logic s_d, r_d, en_d, coll_d;
  logic [1:0] rise;

  // ---------------------------------------------------------------------------
  // Input sampling
  // ---------------------------------------------------------------------------
`ifdef SR_CMD_SYNC_EN
  logic [1:0] meta_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      samp_q <= '0;
    end else begin
      meta_q <= raw;
      samp_q <= meta_q;
    end
  end
`else
  // NOTE: sequential state is assigned with non-blocking (<=) so every flop
  // captures pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) samp_q <= '0;
    else     samp_q <= raw;
  end
`endif

  // ---------------------------------------------------------------------------
  // Debounce: a level flips only after DEBOUNCE_CYCLES consecutive samples
  // that differ from it. Any sample that agrees with the level restarts the count.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    deb_d = deb_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (samp_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_MAX) deb_d[i] = samp_q[i];
        else                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Rising-edge detect and command encoding
  // ---------------------------------------------------------------------------
  assign rise = deb_q & ~deb_dly_q;

  always_comb begin
    s_d    = rise[0] & ~rise[1];
    r_d    = rise[1] & ~rise[0];
    en_d   = rise[0] ^ rise[1];
    coll_d = rise[0] & rise[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q     <= '0;
      deb_dly_q <= '0;
      cnt_q[0]  <= '0;
      cnt_q[1]  <= '0;
      s_q       <= 1'b0;
      r_q       <= 1'b0;
      en_q      <= 1'b0;
      coll_q    <= 1'b0;
    end else begin
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      cnt_q[0]  <= cnt_d[0];
      cnt_q[1]  <= cnt_d[1];
      s_q       <= s_d;
      r_q       <= r_d;
      en_q      <= en_d;
      coll_q    <= coll_d;
    end
  end

  assign S         = s_q;
  assign R         = r_q;
  assign enable    = en_q;
  assign collision = coll_q;

endmodule

// File: tb/tb_sr_cmd_debouncer.sv
// -----------------------------------------------------------------------------
// tb_sr_cmd_debouncer
//   Directed bench for sr_cmd_debouncer with DEBOUNCE_CYCLES=4. Inputs change
//   1 time unit after a posedge, and outputs are observed at that same point.
//   "Edge k" is the k-th posedge after an input is raised, and edge 0 is the
//   first posedge that samples the input high. A pulse is expected to be
//   visible just after edge LAT.
// -----------------------------------------------------------------------------
module tb_sr_cmd_debouncer;

  localparam int DEB = 4;
`ifdef SR_CMD_SYNC_EN
  localparam int LAT = DEB + 2;
`else
  localparam int LAT = DEB + 1;
`endif

  logic clk = 1'b0;
  logic rst, set_in, reset_in;
  logic S, R, enable, collision;

  int n_vec = 0;
  int n_err = 0;

  sr_cmd_debouncer #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .set_in    (set_in),
    .reset_in  (reset_in),
    .S         (S),
    .R         (R),
    .enable    (enable),
    .collision (collision)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic es, input logic er,
                           input logic ee, input logic ec);
    check({tag, ".S"},         S,         es);
    check({tag, ".R"},         R,         er);
    check({tag, ".enable"},    enable,    ee);
    check({tag, ".collision"}, collision, ec);
    // The forbidden command must never appear.
    check({tag, ".S&R"},       S & R,     1'b0);
  endtask

  task automatic idle(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      step();
      check_out(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    rst      = 1'b1;
    set_in   = 1'b0;
    reset_in = 1'b0;

    // 1. Reset held for 3 cycles with inputs low. All outputs stay 0, during reset and after it.
    for (int k = 0; k < 3; k++) begin
      step();
      check_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b0;
    idle("post_reset", 3);

    // 2. set_in held 12 cycles. Exactly one S pulse, just after edge LAT.
    set_in = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      check_out($sformatf("set_hold[%0d]", k), k == LAT, 1'b0, k == LAT, 1'b0);
    end
    set_in = 1'b0;
    idle("set_release", 10);

    // 3. Glitch of 3 samples. There is never a pulse, and the counter falls back to 0.
    set_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_out("glitch", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    set_in = 1'b0;
    idle("glitch_after", 9);
    check("glitch.cnt", dut.cnt_q[0] == '0, 1'b1);

    // 4. Both requests rise together, held 8. Only collision pulses.
    set_in   = 1'b1;
    reset_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      check_out($sformatf("both[%0d]", k), 1'b0, 1'b0, 1'b0, k == LAT);
    end
    set_in   = 1'b0;
    reset_in = 1'b0;
    idle("both_release", 10);

    // 5. reset_in high 8, low 6, high 8. Two R pulses, one per high phase.
    for (int k = 0; k < 22; k++) begin
      reset_in = (k < 8) || (k >= 14);
      step();
      check_out($sformatf("r_train[%0d]", k), 1'b0,
                (k == LAT) || (k == 14 + LAT), (k == LAT) || (k == 14 + LAT), 1'b0);
    end
    reset_in = 1'b0;
    idle("r_train_release", 10);

    // 6. set_in held through a reset that covers edges 2 and 3. Counting
    //    restarts from edge 4, so the single S pulse appears after edge 4+LAT.
    set_in = 1'b1;
    for (int k = 0; k < 16; k++) begin
      rst = (k == 2) || (k == 3);
      step();
      check_out($sformatf("rst_mid[%0d]", k), k == 4 + LAT, 1'b0, k == 4 + LAT, 1'b0);
    end
    rst    = 1'b0;
    set_in = 1'b0;
    idle("rst_mid_release", 10);

    // 7. set_in rises and reset_in rises one cycle later. The result is two separate pulses, in order.
    set_in = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      reset_in = 1'b1;
      check_out($sformatf("staggered[%0d]", k), k == LAT, k == LAT + 1,
                (k == LAT) || (k == LAT + 1), 1'b0);
    end
    set_in   = 1'b0;
    reset_in = 1'b0;
    idle("staggered_release", 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
